// File: rtl/alu_issue_buffer.sv
// Two-entry skid buffer between decode and the ALU, with operand-2 select and writeback forwarding.
// Optional illegal-opcode flagging is enabled by defining ALU_ISSUE_OPCHECK_EN.
module alu_issue_buffer #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [RADDR-1:0] i_rs1,
    input  logic [RADDR-1:0] i_rs2,
    input  logic [RADDR-1:0] i_rd,
    input  logic [XLEN-1:0]  i_operand1,
    input  logic [XLEN-1:0]  i_operand2,
    input  logic [XLEN-1:0]  i_imm,
    input  logic             i_useImm,
    input  logic [3:0]       i_ALUControl,
    input  logic             i_fwdValid,
    input  logic [RADDR-1:0] i_fwdRd,
    input  logic [XLEN-1:0]  i_fwdData,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_operand1,
    output logic [XLEN-1:0]  o_operand2,
    output logic [3:0]       o_ALUControl,
`ifdef ALU_ISSUE_OPCHECK_EN
    output logic             o_illegal,
`endif
    output logic [RADDR-1:0] o_rd
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic [RADDR-1:0] rd;
        logic             useImm;
        logic [3:0]       aluCtl;
`ifdef ALU_ISSUE_OPCHECK_EN
        logic             illegal;
`endif
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t capEntry, headSnoop, skidSnoop;
    logic   inFire, outFire;

    // Register 0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic fwdHit(input logic [RADDR-1:0] rs, input logic fv,
                                    input logic [RADDR-1:0] frd);
        return fv && (frd != '0) && (frd == rs);
    endfunction

    function automatic entry_t snoop(input entry_t e, input logic fv,
                                     input logic [RADDR-1:0] frd, input logic [XLEN-1:0] fdata);
        entry_t r;
        r = e;
        if (fwdHit(e.rs1, fv, frd)) r.op1 = fdata;
        if (!e.useImm && fwdHit(e.rs2, fv, frd)) r.op2 = fdata;
        return r;
    endfunction

`ifdef ALU_ISSUE_OPCHECK_EN
    function automatic logic isLegal(input logic [3:0] ctl);
        case (ctl)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd8, 4'd9, 4'd10: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    assign o_ready = (state_q != TWO);
    assign o_valid = (state_q != EMPTY);
    assign inFire  = i_valid && o_ready;
    assign outFire = o_valid && i_ready;

    always_comb begin
        capEntry        = '0;
        capEntry.rs1    = i_rs1;
        capEntry.rs2    = i_rs2;
        capEntry.rd     = i_rd;
        capEntry.useImm = i_useImm;
        capEntry.aluCtl = i_ALUControl;
        capEntry.op1    = fwdHit(i_rs1, i_fwdValid, i_fwdRd) ? i_fwdData : i_operand1;
        if (i_useImm)
            capEntry.op2 = i_imm;
        else
            capEntry.op2 = fwdHit(i_rs2, i_fwdValid, i_fwdRd) ? i_fwdData : i_operand2;
`ifdef ALU_ISSUE_OPCHECK_EN
        capEntry.illegal = !isLegal(i_ALUControl);
`endif
    end

    // Held entries keep listening to writeback; the skid entry's snooped copy is what moves to head.
    always_comb begin
        headSnoop = snoop(head_q, i_fwdValid, i_fwdRd, i_fwdData);
        skidSnoop = snoop(skid_q, i_fwdValid, i_fwdRd, i_fwdData);
        state_d   = state_q;
        head_d    = head_q;
        skid_d    = skid_q;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (inFire) begin
                        state_d = ONE;
                        head_d  = capEntry;
                    end
                end
                ONE: begin
                    if (inFire && !outFire) begin
                        state_d = TWO;
                        head_d  = headSnoop;
                        skid_d  = capEntry;
                    end else if (!inFire && outFire) begin
                        state_d = EMPTY;
                    end else if (inFire && outFire) begin
                        head_d  = capEntry;
                    end else begin
                        head_d  = headSnoop;
                    end
                end
                TWO: begin
                    if (outFire) begin
                        state_d = ONE;
                        head_d  = skidSnoop;
                    end else begin
                        head_d  = headSnoop;
                        skid_d  = skidSnoop;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign o_operand1 = head_q.op1;
    assign o_operand2 = head_q.op2;
    assign o_rd       = head_q.rd;

    // Illegal ops are steered to add so the ALU result stays defined.
`ifdef ALU_ISSUE_OPCHECK_EN
    assign o_illegal    = head_q.illegal;
    assign o_ALUControl = head_q.illegal ? 4'b0010 : head_q.aluCtl;
`else
    assign o_ALUControl = head_q.aluCtl;
`endif

endmodule

// File: doc/alu_issue_buffer.md
Name: alu_issue_buffer

Overview:
- Execute-stage issue buffer directly upstream of the ALU.
- Accepts decoded ops from decode via a valid/ready handshake and holds them in a 2-entry skid buffer.
- Selects register or immediate for operand 2 and applies writeback forwarding, both at capture and while entries are held.
- Drives the ALU's operand and control inputs plus a destination tag.

Parameters:
- XLEN, 32, operand/result width.
- RADDR, 5, register index width; index 0 is the hardwired zero register.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_flush  input  1  synchronous flush of all buffered entries.
- i_valid  input  1  decode presents an op.
- o_ready  output  1  buffer can accept; handshake fires when i_valid && o_ready.
- i_rs1, i_rs2  input  RADDR each  source register indices.
- i_rd  input  RADDR  destination register index.
- i_operand1, i_operand2  input  XLEN each  register file read data.
- i_imm  input  XLEN  sign-extended immediate.
- i_useImm  input  1  operand 2 takes i_imm instead of i_operand2.
- i_ALUControl  input  4  ALU op code, passed through.
- i_fwdValid  input  1  writeback is writing a register this cycle.
- i_fwdRd  input  RADDR  writeback destination index.
- i_fwdData  input  XLEN  writeback data.
- o_valid  output  1  head entry valid toward the ALU.
- i_ready  input  1  ALU/EX-MEM accepts head; output fires when o_valid && i_ready.
- o_operand1, o_operand2  output  XLEN each  to ALU operands.
- o_ALUControl  output  4  to ALU control.
- o_rd  output  RADDR  destination tag travelling with the op.

Behaviour:
- Storage: head entry H (drives outputs) and skid entry S. Each holds op1, op2, rs1, rs2, useImm, ALUControl, rd.
- State register, 2 bits:
  - EMPTY = 0 entries.
  - ONE = H valid.
  - TWO = H and S valid.
- o_ready = (state != TWO), decoded from registered state, no combinational path from i_ready. o_valid = (state != EMPTY).
- Transitions (in = input fire, out = output fire):
  - EMPTY: in -> ONE, H <= input.
  - ONE: in && !out -> TWO, S <= input. !in && out -> EMPTY. in && out -> ONE, H <= input.
  - TWO: out -> ONE, H <= S. !out -> hold.
- Latency: an op accepted into EMPTY appears on the outputs the next cycle. Throughput is 1 op/cycle when i_ready is held high.
- Capture forwarding: a source is forwarded when i_fwdValid && i_fwdRd != 0 && i_fwdRd == rsN. Forwarded op1 = i_fwdData, else i_operand1. Op2 = i_imm if i_useImm; else forwarded i_fwdData or i_operand2.
- Held-entry snoop: every cycle, each valid entry that is not leaving applies the same match rule to its stored op1/op2 and overwrites them with i_fwdData. Op2 is not snooped when useImm=1. When an entry moves S->H, the snooped value is the one moved.
- Register 0 is never forwarded.
- i_flush: highest priority. Next state = EMPTY and entries are invalidated; a same-cycle input or output fire has no effect on state. o_ready stays combinationally decoded, so a same-cycle input fire is dropped.
- Reset (i_rst_n low, asynchronous):
  - state = EMPTY, so o_valid = 0 and o_ready = 1.
  - o_operand1, o_operand2, o_ALUControl, o_rd = 0.
  - All entry storage = 0.
- Reset mid-operation discards all entries immediately; no partial transfer.
- Data outputs hold their last values when o_valid = 0. The bench checks data only when o_valid = 1.

Optional Feature:
- Macro ALU_ISSUE_OPCHECK_EN.
- Defined:
  - Adds output o_illegal (1 bit, reset 0), stored per entry.
  - o_illegal = 1 when the head's ALUControl is not one of 0,1,2,3,6,8,9,10.
  - For such entries o_ALUControl is forced to 4'b0010 (add) so the ALU result is defined; the flag travels with the entry through skid and flush.
- Undefined: o_illegal does not exist; ALUControl passes through unmodified.

Test Plan:
- Reset release, i_ready=1; stream 3 ops, ALUControl 2, op1 = 5/6/7, op2 = 1 -> o_valid from the cycle after the first accept; outputs 5/6/7 on consecutive cycles; o_ready stays 1.
- Backpressure: i_ready=0, push ops A, B -> after the second accept o_ready=0 and H=A. Then set i_ready=1 -> A then B emerge, o_ready returns to 1 the cycle after A leaves.
- Capture forwarding: i_rs1=3, i_operand1=0x10, i_fwdValid=1, i_fwdRd=3, i_fwdData=0xAB -> o_operand1=0xAB. Same stimulus with rd=0, rs1=0 -> o_operand1=0x10.
- Snoop: hold op (rs2=4, useImm=0) with i_ready=0, then fwd rd=4 data=0x55 -> o_operand2 becomes 0x55 next cycle. Repeat with useImm=1 and i_imm=9 -> o_operand2 stays 9.
- Flush in TWO with simultaneous i_valid=1 -> next cycle o_valid=0, o_ready=1, and the input op never appears. Async reset pulse mid-stream -> outputs zero immediately.
- With ALU_ISSUE_OPCHECK_EN: ALUControl=4'b0101 -> o_illegal=1, o_ALUControl=2. ALUControl=4'b1010 -> o_illegal=0.
